// File: rtl/motor_cmd_sequencer.sv
// Motor command sequencer: slew-limited PWM command with safe direction reversal,
// braking and a sticky stall fault.
module motor_cmd_sequencer #(
    parameter int K_PWMRES  = 10,
    parameter int K_STALL_W = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_enable,
    input  logic [K_PWMRES-1:0]  i_target_pwm,
    input  logic                 i_target_reverse,
    input  logic                 i_ramp_tick,
    input  logic [3:0]           i_ramp_step,
    input  logic                 i_speed_is_low,
    input  logic [K_STALL_W-1:0] i_stall_timeout,
    output logic [K_PWMRES-1:0]  o_pwm_command,
    output logic                 o_reverse,
    output logic                 o_brake,
    output logic [2:0]           o_state,
    output logic                 o_fault
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RAMP  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DECEL = 3'd3,
        ST_BRAKE = 3'd4,
        ST_FAULT = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [K_PWMRES-1:0]    pwm_q, pwm_d;
    logic                   reverse_q, reverse_d;
    logic                   brake_q, brake_d;
    logic                   fault_q, fault_d;
    logic [K_STALL_W-1:0]   stall_q, stall_d;

    logic [K_PWMRES:0]      pwm_ext, tgt_ext, step_ext, up_sum, dn_diff;
    logic [K_PWMRES-1:0]    slew_pwm, decel_pwm;
    logic                   start_req, exit_req, powered, stall_trip;

    // One extra bit on the slew arithmetic so overshoot and underflow are visible
    assign pwm_ext  = {1'b0, pwm_q};
    assign tgt_ext  = {1'b0, i_target_pwm};
    assign step_ext = {{(K_PWMRES - 3){1'b0}}, i_ramp_step};
    assign up_sum   = pwm_ext + step_ext;
    assign dn_diff  = pwm_ext - step_ext;

    always_comb begin
        slew_pwm = i_target_pwm;
        if (i_ramp_step != 4'd0) begin
            if (pwm_q < i_target_pwm) begin
                slew_pwm = (up_sum >= tgt_ext) ? i_target_pwm : up_sum[K_PWMRES-1:0];
            end else if (pwm_q > i_target_pwm) begin
                slew_pwm = (dn_diff[K_PWMRES] || dn_diff <= tgt_ext) ? i_target_pwm
                                                                     : dn_diff[K_PWMRES-1:0];
            end
        end
    end

    always_comb begin
        decel_pwm = '0;
        if (i_ramp_step != 4'd0 && !dn_diff[K_PWMRES]) begin
            decel_pwm = dn_diff[K_PWMRES-1:0];
        end
    end

    assign start_req  = i_enable && (i_target_pwm != '0);
    assign exit_req   = !i_enable || (i_target_pwm == '0) || (i_target_reverse != reverse_q);
    assign powered    = (state_q == ST_RAMP) || (state_q == ST_RUN);
    assign stall_trip = powered && (i_stall_timeout != '0) && (stall_q == i_stall_timeout);

    always_comb begin
        state_d   = state_q;
        pwm_d     = pwm_q;
        reverse_d = reverse_q;
        stall_d   = '0;

        // Stall counting only while driving a nonzero duty into a motor that isn't moving
        if (powered && pwm_q != '0 && i_speed_is_low) begin
            stall_d = (i_ramp_tick && !(&stall_q)) ? stall_q + 1'b1 : stall_q;
        end

        case (state_q)
            ST_IDLE: begin
                pwm_d = '0;
                if (start_req) begin
                    reverse_d = i_target_reverse;
                    state_d   = ST_RAMP;
                end
            end
            ST_RAMP, ST_RUN: begin
                if (stall_trip) begin
                    state_d = ST_FAULT;
                    pwm_d   = '0;
                    stall_d = '0;
                end else if (exit_req) begin
                    state_d = ST_DECEL;
                end else begin
                    if (i_ramp_tick) begin
                        pwm_d = slew_pwm;
                    end
                    if (state_q == ST_RAMP && pwm_q == i_target_pwm) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_DECEL: begin
                if (i_ramp_tick) begin
                    pwm_d = decel_pwm;
                end
                if (pwm_q == '0) begin
                    state_d = ST_BRAKE;
                end
            end
            ST_BRAKE: begin
                pwm_d = '0;
                if (i_speed_is_low) begin
                    if (start_req) begin
                        reverse_d = i_target_reverse;
                        state_d   = ST_RAMP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_FAULT: begin
                pwm_d = '0;
                if (!i_enable) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pwm_d   = '0;
            end
        endcase

        brake_d = (state_d == ST_IDLE) || (state_d == ST_BRAKE) || (state_d == ST_FAULT);
        fault_d = (state_d == ST_FAULT);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            pwm_q     <= '0;
            reverse_q <= 1'b0;
            brake_q   <= 1'b1;
            fault_q   <= 1'b0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            pwm_q     <= pwm_d;
            reverse_q <= reverse_d;
            brake_q   <= brake_d;
            fault_q   <= fault_d;
            stall_q   <= stall_d;
        end
    end

    assign o_pwm_command = pwm_q;
    assign o_reverse     = reverse_q;
    assign o_brake       = brake_q;
    assign o_state       = state_q;
    assign o_fault       = fault_q;

endmodule

// File: doc/motor_cmd_sequencer.md
Name: motor_cmd_sequencer

Overview:
Command sequencer in front of the motor control datapath. It turns a requested PWM duty and direction into a slew-limited PWM command, plus brake and reverse controls. It does not reverse while the motor is spinning, and it trips a sticky fault when the motor stalls under power. Its outputs drive the PWM command, brake and reverse inputs of the motor control top. The speed-is-low flag comes back from the speed measurement path.

Parameters:
K_PWMRES, 10, PWM command width
K_STALL_W, 8, stall timeout counter width (units of ramp ticks)

Ports:
i_clk  in  1  master clock
i_rst_n  in  1  reset, asynchronous, active-low
i_enable  in  1  drive enable request
i_target_pwm  in  K_PWMRES  requested duty
i_target_reverse  in  1  requested direction (1 = reverse)
i_ramp_tick  in  1  single-cycle slew time-base strobe
i_ramp_step  in  4  duty increment per tick (0 = jump straight to target)
i_speed_is_low  in  1  measured speed below low-speed threshold
i_stall_timeout  in  K_STALL_W  stall limit in ticks (0 = detection disabled)
o_pwm_command  out  K_PWMRES  slewed duty command
o_reverse  out  1  applied direction
o_brake  out  1  brake request
o_state  out  3  FSM state code
o_fault  out  1  sticky stall fault

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, o_pwm_command 0, o_reverse 0, o_brake 1, o_fault 0, stall counter 0.
- State codes: IDLE=0, RAMP=1, RUN=2, DECEL=3, BRAKE=4, FAULT=5. Codes 6 and 7 are unreachable; if entered, go to IDLE next cycle.
- o_brake is 1 in IDLE, BRAKE and FAULT, and 0 elsewhere.
- o_fault is 1 only in FAULT.
- IDLE:
  - o_pwm_command = 0.
  - If i_enable and i_target_pwm != 0: latch o_reverse <= i_target_reverse and go to RAMP.
- RAMP and RUN:
  - On i_ramp_tick, o_pwm_command moves toward i_target_pwm by i_ramp_step.
  - Slew arithmetic uses a K_PWMRES+1-bit sum/difference and clamps to the target, so the result never overshoots or wraps.
  - i_ramp_step = 0 loads the target directly.
  - RAMP goes to RUN on the first cycle where the registered o_pwm_command == i_target_pwm.
  - RUN keeps tracking target changes with the same slew and stays in RUN.
  - i_enable = 0, i_target_pwm = 0, or i_target_reverse != o_reverse: go to DECEL.
- DECEL:
  - On i_ramp_tick, o_pwm_command decreases by i_ramp_step, saturating at 0; step 0 sets 0 immediately.
  - When o_pwm_command == 0, go to BRAKE.
- BRAKE:
  - Wait for i_speed_is_low = 1.
  - Then, if i_enable and i_target_pwm != 0: o_reverse <= i_target_reverse and go to RAMP. Otherwise go to IDLE.
  - o_reverse changes only on the IDLE->RAMP and BRAKE->RAMP transitions.
- Stall counter:
  - In RAMP or RUN with o_pwm_command != 0 and i_speed_is_low = 1, it increments on each i_ramp_tick and saturates at all ones.
  - It clears whenever i_speed_is_low = 0 or the state is not RAMP/RUN.
  - Trip condition: i_stall_timeout != 0 and counter == i_stall_timeout. Next cycle: FAULT, o_pwm_command = 0, counter cleared.
- FAULT is sticky. It is left only when i_enable = 0, going to IDLE on the next cycle.
- Priority within one cycle: stall trip > enable-loss/direction-change exit > slew update. A tick in the same cycle as a trip does not update the PWM.
- The same-cycle tick is applied using current-state rules before a transition takes effect.
- Reset mid-operation returns all outputs to reset values immediately (asynchronous).

Test Plan:
- Reset, then enable with target 100, step 8, ticks every 4 cycles -> PWM 0,8,...,96,100. RAMP->RUN one cycle after reaching 100, brake 0, reverse 0.
- In RUN at 100, toggle i_target_reverse with speed_is_low = 0 -> DECEL down to 0 in steps of 8, then BRAKE held. Assert speed_is_low -> reverse becomes 1, RAMP restarts from 0.
- Step 0, target 300 -> PWM jumps to 300 on the first tick. Then change target to 200 in RUN -> PWM drops directly to 200 while staying in RUN.
- Timeout 5, speed_is_low stuck 1 at PWM > 0 -> FAULT after the 5th tick: PWM 0, brake 1, fault 1. It holds with enable 1 and returns to IDLE one cycle after enable drops.
- Timeout 0, speed_is_low stuck 1 for 300 ticks -> no fault. Also, target 1020 from 1015 with step 15 -> clamps at 1020 with no wrap.
- Assert i_rst_n low during RAMP at PWM 40 -> PWM 0, brake 1, state 0, reverse 0 immediately.
